adc_capture_ctrl: RTL and testbench

- Downstream consumer of the analog ADC wrapper's parallel sample lanes, running in the 500 MHz ADC clock domain.
- Arms on a start command and optionally waits for a rising-level trigger on lane 0.
- Writes a configured number of full-width lane words into a single-port capture buffer.
- In TI48 mode, packs two consecutive 48-lane samples into one buffer word, so buffer width is identical in both modes.

---
 rtl/adc_capture_ctrl.sv | 171 +++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// Capture controller for the ADC lane bus: arms on start, optionally waits for a
// rising lane-0 trigger, then writes full-width lane words (TI48 pairs two samples).
module adc_capture_ctrl #(
    parameter int NLANE = 96,
    parameter int DW    = 9,
    parameter int AW    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NLANE*DW-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                cfg_mode,
    input  logic                cfg_trig_en,
    input  logic [DW-1:0]       cfg_trig_level,
    input  logic [AW:0]         cfg_depth,
    input  logic                start,
    input  logic                abort,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [NLANE*DW-1:0] mem_wdata,
    output logic                busy,
    output logic                done,
    output logic [AW:0]         word_count
);

    localparam int WW = NLANE * DW;
    localparam int HW = (NLANE / 2) * DW;
    localparam logic [AW:0] MAX_DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic            trig_en_q, trig_en_d;
    logic [DW-1:0]   level_q, level_d;
    logic [AW:0]     depth_q, depth_d;
    logic [AW:0]     word_count_q, word_count_d;
    logic            half_q, half_d;
    logic            prev_vld_q, prev_vld_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [WW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   prev_q, prev_d;
    logic [HW-1:0]   lower_q, lower_d;

    logic [DW-1:0]   lane0;
    logic            trig_hit;
    logic            take;

    function automatic logic [AW:0] clamp_depth(input logic [AW:0] d);
        return (d > MAX_DEPTH) ? MAX_DEPTH : d;
    endfunction

    assign lane0    = adc_data[DW-1:0];
    assign trig_hit = prev_vld_q && (prev_q < level_q) && (lane0 >= level_q);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        trig_en_d    = trig_en_q;
        level_d      = level_q;
        depth_d      = depth_q;
        word_count_d = word_count_q;
        half_d       = half_q;
        prev_vld_d   = prev_vld_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        prev_d       = prev_q;
        lower_d      = lower_q;
        take         = 1'b0;

        if (abort) begin
            state_d = IDLE;
            half_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mode_d       = cfg_mode;
                        trig_en_d    = cfg_trig_en;
                        level_d      = cfg_trig_level;
                        depth_d      = clamp_depth(cfg_depth);
                        word_count_d = '0;
                        mem_addr_d   = '0;
                        half_d       = 1'b0;
                        prev_vld_d   = 1'b0;
                        if (cfg_depth == '0)
                            state_d = DONE;
                        else
                            state_d = cfg_trig_en ? WAIT_TRIG : CAPTURE;
                    end
                end
                WAIT_TRIG: begin
                    if (adc_valid) begin
                        prev_d     = lane0;
                        prev_vld_d = 1'b1;
                        if (trig_hit) begin
                            state_d = CAPTURE;
                            take    = 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    // The final write is on the bus this cycle; stop accepting samples.
                    if (word_count_q == depth_q)
                        state_d = DONE;
                    else if (adc_valid)
                        take = 1'b1;
                end
                default: state_d = IDLE;
            endcase

            // Sample datapath: TI96 writes every sample, TI48 writes every second one.
            if (take) begin
                if (!mode_q || half_q) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = word_count_q[AW-1:0];
                    word_count_d = word_count_q + (AW+1)'(1);
                    mem_wdata_d  = mode_q ? {adc_data[HW-1:0], lower_q} : adc_data;
                    half_d       = 1'b0;
                end else begin
                    lower_d = adc_data[HW-1:0];
                    half_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            trig_en_q    <= 1'b0;
            level_q      <= '0;
            depth_q      <= '0;
            word_count_q <= '0;
            half_q       <= 1'b0;
            prev_vld_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            trig_en_q    <= trig_en_d;
            level_q      <= level_d;
            depth_q      <= depth_d;
            word_count_q <= word_count_d;
            half_q       <= half_d;
            prev_vld_q   <= prev_vld_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Pure data holding registers; their contents are qualified by prev_vld_q / half_q.
    always_ff @(posedge clk) begin
        prev_q  <= prev_d;
        lower_q <= lower_d;
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign busy       = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized bench for adc_capture_ctrl: each capture run is checked against a
// sample-stream model (trigger search, pairing, depth clamp, write timing).
`timescale 1ns/1ps
module tb_adc_capture_ctrl;

    localparam int NLANE = 96;
    localparam int DW    = 9;
    localparam int AW    = 10;
    localparam int WW    = NLANE * DW;
    localparam int HW    = (NLANE / 2) * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic [WW-1:0] adc_data;
    logic          adc_valid;
    logic          cfg_mode;
    logic          cfg_trig_en;
    logic [DW-1:0] cfg_trig_level;
    logic [AW:0]   cfg_depth;
    logic          start;
    logic          abort;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;

    adc_capture_ctrl #(.NLANE(NLANE), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
        .cfg_mode(cfg_mode), .cfg_trig_en(cfg_trig_en), .cfg_trig_level(cfg_trig_level),
        .cfg_depth(cfg_depth), .start(start), .abort(abort), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fold(input logic [WW-1:0] w);
        logic [63:0] h = '0;
        for (int i = 0; i < NLANE; i++)
            h = {h[58:0], h[63:59]} ^ 64'(w[i*DW +: DW]);
        return h;
    endfunction

    function automatic logic [WW-1:0] rword(input logic [DW-1:0] l0, input bit force_l0);
        logic [WW-1:0] w;
        for (int i = 0; i < NLANE; i++)
            w[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
        if (force_l0) w[DW-1:0] = l0;
        return w;
    endfunction

    // Monitor: observed writes and the first done cycle after the arming start.
    bit            mon_en = 0;
    int            start_cyc = 0;
    int            done_cyc = -1;
    logic [AW:0]   wc_s1;
    int            w_cyc[$];
    logic [AW-1:0] w_addr[$];
    logic [WW-1:0] w_data[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we) begin
                w_cyc.push_back(cyc);
                w_addr.push_back(mem_addr);
                w_data.push_back(mem_wdata);
            end
            if (done && done_cyc < 0 && cyc > start_cyc) done_cyc = cyc;
            if (cyc == start_cyc + 1) wc_s1 = word_count;
        end
    end

    bit            sv[$];
    logic [WW-1:0] sd[$];

    task automatic clear_run();
        sv.delete(); sd.delete();
        w_cyc.delete(); w_addr.delete(); w_data.delete();
        done_cyc = -1;
    endtask

    task automatic idle_inputs();
        adc_valid = 0; start = 0; abort = 0;
    endtask

    task automatic run_case(input string name, input bit mode, input bit ten,
                            input logic [DW-1:0] lvl, input logic [AW:0] dcfg,
                            input int mid_start);
        int            vc[$];
        logic [WW-1:0] vd[$];
        int first, n, avail, nexp, dclamp, s0, lastc;
        bit complete;
        w_cyc.delete(); w_addr.delete(); w_data.delete();
        done_cyc = -1;
        @(posedge clk); #1;
        cfg_mode = mode; cfg_trig_en = ten; cfg_trig_level = lvl; cfg_depth = dcfg;
        start = 1; abort = 0; adc_valid = 0;
        start_cyc = cyc; mon_en = 1;
        for (int i = 0; i < sv.size(); i++) begin
            @(posedge clk); #1;
            start = (i == mid_start);
            cfg_mode = 1'($urandom); cfg_trig_en = 1'($urandom);
            cfg_trig_level = DW'($urandom); cfg_depth = (AW+1)'($urandom);
            adc_valid = sv[i]; adc_data = sd[i];
            if (sv[i]) begin vc.push_back(cyc); vd.push_back(sd[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; idle_inputs();
        end
        @(negedge clk);

        dclamp = (dcfg > (1 << AW)) ? (1 << AW) : int'(dcfg);
        n = vd.size();
        first = -1;
        if (!ten) first = 0;
        else
            for (int i = 1; i < n; i++)
                if (vd[i-1][DW-1:0] < lvl && vd[i][DW-1:0] >= lvl) begin first = i; break; end
        avail = (first < 0) ? 0 : (mode ? (n - first) / 2 : n - first);
        nexp = (dclamp < avail) ? dclamp : avail;
        complete = (nexp == dclamp);
        lastc = start_cyc;

        chk({name, ".nwr"}, 64'(w_cyc.size()), 64'(nexp));
        for (int k = 0; k < nexp && k < w_cyc.size(); k++) begin
            logic [WW-1:0] ew;
            s0 = first + (mode ? 2 * k : k);
            ew = mode ? {vd[s0+1][HW-1:0], vd[s0][HW-1:0]} : vd[s0];
            lastc = vc[mode ? s0 + 1 : s0] + 1;
            chk({name, ".addr"}, 64'(w_addr[k]), 64'(k % (1 << AW)));
            chk({name, ".wcyc"}, 64'(w_cyc[k]), 64'(lastc));
            chk({name, ".lane0"}, 64'(w_data[k][DW-1:0]), 64'(ew[DW-1:0]));
            chk({name, ".laneh"}, 64'(w_data[k][HW +: DW]), 64'(ew[HW +: DW]));
            chk({name, ".word"}, fold(w_data[k]), fold(ew));
        end
        chk({name, ".done_cyc"}, 64'(done_cyc), complete ? 64'(lastc + 1) : 64'(-1));
        chk({name, ".wc_start"}, 64'(wc_s1), 64'(0));
        chk({name, ".wc"}, 64'(word_count), 64'(nexp));
        chk({name, ".busy"}, 64'(busy), 64'(!complete));
        chk({name, ".done"}, 64'(done), 64'(complete));
        if (!complete) begin
            @(posedge clk); #1; abort = 1;
            @(posedge clk); #1; abort = 0;
            @(negedge clk);
            chk({name, ".ab_busy"}, 64'(busy), 64'(0));
            chk({name, ".ab_done"}, 64'(done), 64'(0));
            chk({name, ".ab_wc"}, 64'(word_count), 64'(nexp));
        end
        mon_en = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; idle_inputs();
        adc_data = '0; cfg_mode = 0; cfg_trig_en = 0; cfg_trig_level = '0; cfg_depth = '0;
        #3;
        chk("rst.mem_we", 64'(mem_we), 64'(0));
        chk("rst.mem_addr", 64'(mem_addr), 64'(0));
        chk("rst.mem_wdata", fold(mem_wdata), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.wc", 64'(word_count), 64'(0));
        @(posedge clk); @(posedge clk); #1; reset = 0;

        // TI96, immediate capture, lane0 ramp
        clear_run();
        for (int i = 0; i < 8; i++) begin sv.push_back(1); sd.push_back(rword(DW'(i), 1)); end
        run_case("t1", 0, 0, '0, 4, -1);

        // TI48 pair packing
        clear_run();
        for (int i = 0; i < 6; i++) begin sv.push_back(1); sd.push_back(rword(DW'(10 + i), 1)); end
        run_case("t2", 1, 0, '0, 2, -1);

        // TI96 rising trigger at level 256
        clear_run();
        begin
            int seq[8] = '{300, 100, 200, 255, 256, 400, 500, 0};
            for (int i = 0; i < 8; i++) begin sv.push_back(1); sd.push_back(rword(DW'(seq[i]), 1)); end
        end
        run_case("t3", 0, 1, DW'(256), 4, -1);
        clear_run();
        begin
            int seq[8] = '{300, 100, 200, 255, 256, 400, 500, 0};
            for (int i = 0; i < 8; i++) begin sv.push_back(1); sd.push_back(rword(DW'(seq[i]), 1)); end
        end
        run_case("t3b", 0, 1, DW'(256), 2, -1);

        // TI48 with gapped valid
        clear_run();
        for (int i = 0; i < 16; i++) begin sv.push_back(i % 2 == 0); sd.push_back(rword(DW'(i), 1)); end
        run_case("t4", 1, 0, '0, 3, -1);

        // abort together with start after two writes
        clear_run();
        @(posedge clk); #1;
        cfg_mode = 0; cfg_trig_en = 0; cfg_depth = 8; start = 1; abort = 0; adc_valid = 0;
        start_cyc = cyc; mon_en = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            adc_valid = 1; adc_data = rword(DW'(i), 1);
            start = (i == 2); abort = (i == 2);
        end
        @(posedge clk); #1; idle_inputs();
        @(negedge clk);
        chk("t5.nwr", 64'(w_cyc.size()), 64'(2));
        if (w_cyc.size() >= 2) begin
            chk("t5.addr1", 64'(w_addr[1]), 64'(1));
            chk("t5.wcyc1", 64'(w_cyc[1]), 64'(start_cyc + 3));
        end
        chk("t5.wc", 64'(word_count), 64'(2));
        chk("t5.done", 64'(done), 64'(0));
        chk("t5.busy", 64'(busy), 64'(0));
        chk("t5.done_cyc", 64'(done_cyc), 64'(-1));
        mon_en = 0;
        clear_run();
        for (int i = 0; i < 10; i++) begin sv.push_back(1); sd.push_back(rword(DW'(i), 1)); end
        run_case("t5r", 0, 0, '0, 8, -1);

        // zero depth, then clamped depth with a start pulse mid-capture
        clear_run();
        run_case("t6z", 0, 0, '0, 0, -1);
        clear_run();
        for (int i = 0; i < 1030; i++) begin sv.push_back(1); sd.push_back(rword('0, 0)); end
        run_case("t6c", 0, 0, '0, (AW+1)'((1 << AW) + 5), 20);

        // trigger level 0 can never be crossed
        clear_run();
        for (int i = 0; i < 20; i++) begin sv.push_back(1); sd.push_back(rword('0, 0)); end
        run_case("t7", 0, 1, '0, 3, -1);

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            clear_run();
            for (int i = 0; i < 80; i++) begin
                sv.push_back($urandom_range(0, 3) != 0);
                sd.push_back(rword('0, 0));
            end
            run_case($sformatf("rnd%0d", r), 1'($urandom), 1'($urandom),
                     DW'($urandom), (AW+1)'($urandom_range(1, 24)), -1);
        end

        // asynchronous reset in the middle of a capture
        clear_run();
        @(posedge clk); #1;
        cfg_mode = 0; cfg_trig_en = 0; cfg_depth = 100; start = 1; adc_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; start = 0; adc_valid = 1; adc_data = rword('0, 0);
        end
        @(negedge clk);
        chk("ar.busy_pre", 64'(busy), 64'(1));
        #1 reset = 1;
        #1;
        chk("ar.mem_we", 64'(mem_we), 64'(0));
        chk("ar.mem_addr", 64'(mem_addr), 64'(0));
        chk("ar.wdata", fold(mem_wdata), 64'(0));
        chk("ar.busy", 64'(busy), 64'(0));
        chk("ar.wc", 64'(word_count), 64'(0));
        idle_inputs();
        @(posedge clk); #1; reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
